// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: walks the columns one tick at a time, debounces the first
// row seen, and emits registered press/repeat/release events with a linear key code.
module keypad_scan_ctrl #(
   parameter int ROWS     = 4,
   parameter int COLS     = 3,
   parameter int DIV      = 12500,
   parameter int DEBOUNCE = 4,
   parameter int REPEAT   = 0,
   parameter int CW       = $clog2(ROWS * COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] key_row,
   output logic [COLS-1:0] key_col,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_rpt,
   output logic            key_release,
   output logic            key_held
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW = $clog2(DIV);
   localparam int NW = $clog2(DEBOUNCE + 1);
   localparam int PW = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, CONFIRM, HELD} state_t;

   state_t          state, state_n;
   logic [KW-1:0]   col, col_n, col_adv;
   logic [RW-1:0]   row, row_n;
   logic [NW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   rcnt, rcnt_n;
   logic [ROWS-1:0] rs_meta, rs;
   logic [DW-1:0]   div_cnt;
   logic            tick, row_hit, cnt_last, rcnt_last;
   logic            press_ev, rpt_ev, rel_ev;
   logic [COLS-1:0] col_drive_n;
   logic [CW-1:0]   code_n;
   logic            held_n;

   function automatic logic [RW-1:0] lowest_row(input logic [ROWS-1:0] v);
      lowest_row = '0;
      for (int i = ROWS - 1; i >= 0; i--)
         if (v[i]) lowest_row = RW'(i);
   endfunction

   function automatic logic [CW-1:0] encode(input logic [RW-1:0] r, input logic [KW-1:0] c);
      return CW'(int'(r) * COLS + int'(c));
   endfunction

   // NOTE: key_row is asynchronous to clk, so only the second flop's output may feed logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_meta <= '0;
         rs      <= '0;
      end else begin
         rs_meta <= key_row;
         rs      <= rs_meta;
      end
   end

   assign tick = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) div_cnt <= '0;
      else      div_cnt <= tick ? '0 : div_cnt + 1'b1;
   end

   assign col_adv   = (col == KW'(COLS - 1)) ? '0 : col + 1'b1;
   assign row_hit   = rs[row];
   assign cnt_last  = (cnt == NW'(DEBOUNCE - 1));
   assign rcnt_last = (rcnt == PW'(REPEAT - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
         cnt   <= '0;
         rcnt  <= '0;
      end else begin
         state <= state_n;
         col   <= col_n;
         row   <= row_n;
         cnt   <= cnt_n;
         rcnt  <= rcnt_n;
      end
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_n  = state;
      col_n    = col;
      row_n    = row;
      cnt_n    = cnt;
      rcnt_n   = rcnt;
      press_ev = 1'b0;
      rpt_ev   = 1'b0;
      rel_ev   = 1'b0;
      if (tick) begin
         unique case (state)
            IDLE: begin
               state_n = SCAN;
               col_n   = '0;
            end
            SCAN: begin
               if (|rs) begin
                  row_n = lowest_row(rs);
                  cnt_n = NW'(1);
                  if (DEBOUNCE == 1) begin
                     press_ev = 1'b1;
                     state_n  = HELD;
                     cnt_n    = '0;
                     rcnt_n   = '0;
                  end else begin
                     state_n = CONFIRM;
                  end
               end else begin
                  col_n = col_adv;
               end
            end
            CONFIRM: begin
               if (row_hit) begin
                  if (cnt_last) begin
                     press_ev = 1'b1;
                     state_n  = HELD;
                     cnt_n    = '0;
                     rcnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  state_n = SCAN;
                  col_n   = col_adv;
                  cnt_n   = '0;
               end
            end
            HELD: begin
               if (!row_hit) begin
                  if (cnt_last) begin
                     rel_ev  = 1'b1;
                     state_n = SCAN;
                     col_n   = col_adv;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n = '0;
                  if (REPEAT != 0) begin
                     if (rcnt_last) begin
                        rpt_ev = 1'b1;
                        rcnt_n = '0;
                     end else begin
                        rcnt_n = rcnt + 1'b1;
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Outputs are computed from the upcoming state so the registered pins line up with it.
   always_comb begin
      code_n      = key_code;
      held_n      = key_held;
      col_drive_n = (state_n == IDLE) ? '0 : COLS'(1) << col_n;
      if (press_ev) begin
         code_n = encode(row_n, col);
         held_n = 1'b1;
      end
      if (rel_ev) held_n = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_col     <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_rpt     <= 1'b0;
         key_release <= 1'b0;
         key_held    <= 1'b0;
      end else begin
         key_col     <= col_drive_n;
         key_code    <= code_n;
         key_valid   <= press_ev | rpt_ev;
         key_rpt     <= rpt_ev;
         key_release <= rel_ev;
         key_held    <= held_n;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a cycle-exact vector table for scan, press, bounce
// and multi-key behaviour, plus hand sequences for reset in HELD and auto-repeat.
module tb_keypad_scan_ctrl;

   typedef struct {
      int         at;
      logic [3:0] drv;
      logic [2:0] col;
      logic       valid;
      logic       rpt;
      logic       rel;
      logic       held;
      logic [3:0] code;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_row_m, key_row_r;
   logic [2:0] key_col_m, key_col_r;
   logic [3:0] key_code_m, key_code_r;
   logic       key_valid_m, key_rpt_m, key_release_m, key_held_m;
   logic       key_valid_r, key_rpt_r, key_release_r, key_held_r;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;
   vec_t main_q[$];
   vec_t rpt_q[$];

   always #5 clk = ~clk;

   keypad_scan_ctrl #(.ROWS(4), .COLS(3), .DIV(4), .DEBOUNCE(3), .REPEAT(0)) u_main (
      .clk(clk), .rst(rst), .key_row(key_row_m), .key_col(key_col_m), .key_code(key_code_m),
      .key_valid(key_valid_m), .key_rpt(key_rpt_m), .key_release(key_release_m), .key_held(key_held_m)
   );

   keypad_scan_ctrl #(.ROWS(4), .COLS(3), .DIV(4), .DEBOUNCE(3), .REPEAT(5)) u_rpt (
      .clk(clk), .rst(rst), .key_row(key_row_r), .key_col(key_col_r), .key_code(key_code_r),
      .key_valid(key_valid_r), .key_rpt(key_rpt_r), .key_release(key_release_r), .key_held(key_held_r)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int at, input logic [3:0] drv, input logic [2:0] col,
                               input logic v, input logic p, input logic r, input logic h,
                               input logic [3:0] c);
      vec_t x;
      x.at = at; x.drv = drv; x.col = col; x.valid = v;
      x.rpt = p; x.rel = r; x.held = h; x.code = c;
      return x;
   endfunction

   // Advance to the falling edge that follows rising edge number target after reset release.
   task automatic to_edge(input int target);
      if (target > edge_n) begin
         while (edge_n < target) begin
            @(posedge clk);
            edge_n++;
         end
         @(negedge clk);
      end
   endtask

   task automatic cmp_vec(input string tag, input vec_t v, input logic [2:0] col,
                          input logic valid, input logic rpt, input logic rel,
                          input logic held, input logic [3:0] code);
      check($sformatf("%s@%0d col", tag, v.at), 32'(col), 32'(v.col));
      check($sformatf("%s@%0d valid", tag, v.at), 32'(valid), 32'(v.valid));
      check($sformatf("%s@%0d rpt", tag, v.at), 32'(rpt), 32'(v.rpt));
      check($sformatf("%s@%0d release", tag, v.at), 32'(rel), 32'(v.rel));
      check($sformatf("%s@%0d held", tag, v.at), 32'(held), 32'(v.held));
      check($sformatf("%s@%0d code", tag, v.at), 32'(code), 32'(v.code));
   endtask

   initial begin
      //                 at   drive    col     v  p  r  h  code
      main_q.push_back(mk(3,  4'b0000, 3'b000, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(4,  4'b0000, 3'b001, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(8,  4'b0000, 3'b010, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(12, 4'b0000, 3'b100, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(16, 4'b0000, 3'b001, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(24, 4'b0010, 3'b100, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(28, 4'b0010, 3'b100, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(35, 4'b0010, 3'b100, 0, 0, 0, 0, 4'd0));
      main_q.push_back(mk(36, 4'b0010, 3'b100, 1, 0, 0, 1, 4'd5));
      main_q.push_back(mk(37, 4'b0000, 3'b100, 0, 0, 0, 1, 4'd5));
      main_q.push_back(mk(47, 4'b0000, 3'b100, 0, 0, 0, 1, 4'd5));
      main_q.push_back(mk(48, 4'b0000, 3'b001, 0, 0, 1, 0, 4'd5));
      main_q.push_back(mk(49, 4'b0001, 3'b001, 0, 0, 0, 0, 4'd5));
      main_q.push_back(mk(56, 4'b0000, 3'b001, 0, 0, 0, 0, 4'd5));
      main_q.push_back(mk(60, 4'b0100, 3'b010, 0, 0, 0, 0, 4'd5));
      main_q.push_back(mk(61, 4'b0100, 3'b010, 0, 0, 0, 0, 4'd5));
      main_q.push_back(mk(72, 4'b0100, 3'b010, 1, 0, 0, 1, 4'd7));
      main_q.push_back(mk(73, 4'b0000, 3'b010, 0, 0, 0, 1, 4'd7));
      main_q.push_back(mk(76, 4'b0100, 3'b010, 0, 0, 0, 1, 4'd7));
      main_q.push_back(mk(81, 4'b0000, 3'b010, 0, 0, 0, 1, 4'd7));
      main_q.push_back(mk(88, 4'b0000, 3'b010, 0, 0, 0, 1, 4'd7));
      main_q.push_back(mk(92, 4'b0000, 3'b100, 0, 0, 1, 0, 4'd7));
      main_q.push_back(mk(100, 4'b1010, 3'b010, 0, 0, 0, 0, 4'd7));
      main_q.push_back(mk(112, 4'b1010, 3'b010, 1, 0, 0, 1, 4'd4));
      main_q.push_back(mk(113, 4'b1000, 3'b010, 0, 0, 0, 1, 4'd4));
      main_q.push_back(mk(120, 4'b1000, 3'b010, 0, 0, 0, 1, 4'd4));
      main_q.push_back(mk(124, 4'b0000, 3'b100, 0, 0, 1, 0, 4'd4));
      main_q.push_back(mk(128, 4'b1000, 3'b001, 0, 0, 0, 0, 4'd4));
      main_q.push_back(mk(140, 4'b1000, 3'b001, 1, 0, 0, 1, 4'd9));
      main_q.push_back(mk(141, 4'b1000, 3'b001, 0, 0, 0, 1, 4'd9));

      // Auto-repeat instance: key 8 held, repeats every 5 ticks after the press.
      rpt_q.push_back(mk(12, 4'b0100, 3'b100, 0, 0, 0, 0, 4'd0));
      rpt_q.push_back(mk(24, 4'b0100, 3'b100, 1, 0, 0, 1, 4'd8));
      rpt_q.push_back(mk(25, 4'b0100, 3'b100, 0, 0, 0, 1, 4'd8));
      rpt_q.push_back(mk(43, 4'b0100, 3'b100, 0, 0, 0, 1, 4'd8));
      rpt_q.push_back(mk(44, 4'b0100, 3'b100, 1, 1, 0, 1, 4'd8));
      rpt_q.push_back(mk(45, 4'b0100, 3'b100, 0, 0, 0, 1, 4'd8));
      rpt_q.push_back(mk(64, 4'b0100, 3'b100, 1, 1, 0, 1, 4'd8));
      rpt_q.push_back(mk(84, 4'b0100, 3'b100, 1, 1, 0, 1, 4'd8));
      rpt_q.push_back(mk(85, 4'b0000, 3'b100, 0, 0, 0, 1, 4'd8));
      rpt_q.push_back(mk(96, 4'b0000, 3'b001, 0, 0, 1, 0, 4'd8));
      rpt_q.push_back(mk(104, 4'b0000, 3'b100, 0, 0, 0, 0, 4'd8));

      rst       = 1'b0;
      key_row_m = 4'b0000;
      key_row_r = 4'b0000;
      repeat (10) @(negedge clk);
      check("reset col", 32'(key_col_m), 32'd0);
      check("reset code", 32'(key_code_m), 32'd0);
      check("reset pulses", 32'({key_valid_m, key_rpt_m, key_release_m, key_held_m}), 32'd0);

      rst    = 1'b1;
      edge_n = 0;
      foreach (main_q[i]) begin
         to_edge(main_q[i].at);
         cmp_vec("main", main_q[i], key_col_m, key_valid_m, key_rpt_m, key_release_m,
                 key_held_m, key_code_m);
         key_row_m = main_q[i].drv;
      end

      // Reset while key 9 is held: everything clears at once, without waiting for clk.
      to_edge(142);
      check("pre-reset held", 32'(key_held_m), 32'd1);
      rst = 1'b0;
      #1;
      check("mid-held reset col", 32'(key_col_m), 32'd0);
      check("mid-held reset code", 32'(key_code_m), 32'd0);
      check("mid-held reset held", 32'(key_held_m), 32'd0);
      check("mid-held reset pulses", 32'({key_valid_m, key_rpt_m, key_release_m}), 32'd0);
      key_row_m = 4'b0000;
      repeat (10) @(negedge clk);
      check("in-reset held", 32'(key_held_m), 32'd0);
      check("in-reset release", 32'(key_release_m), 32'd0);

      rst    = 1'b1;
      edge_n = 0;
      begin
         int idx = 0;
         for (int e = 1; e <= 110; e++) begin
            to_edge(e);
            check($sformatf("post-reset release@%0d", e), 32'(key_release_m), 32'd0);
            check($sformatf("post-reset valid@%0d", e), 32'(key_valid_m), 32'd0);
            if (idx < rpt_q.size() && rpt_q[idx].at == e) begin
               cmp_vec("rpt", rpt_q[idx], key_col_r, key_valid_r, key_rpt_r, key_release_r,
                       key_held_r, key_code_r);
               key_row_r = rpt_q[idx].drv;
               idx++;
            end else begin
               check($sformatf("rpt quiet valid@%0d", e), 32'(key_valid_r),
                     32'((e == 64 || e == 84) ? 1 : 0));
            end
         end
         check("rpt table consumed", 32'(idx), 32'(rpt_q.size()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner for the game board front end. It drives one keypad column at a time and samples the row lines. Each key press is debounced, and the block emits one-cycle press and release events carrying a linear key code, with optional auto-repeat. It sits between the keypad pins and the game/menu control logic, which maps key codes to cells and commands.

## Interface
Parameters:
- ROWS, default 4: number of row inputs.
- COLS, default 3: number of driven columns.
- DIV, default 12500: clk cycles per scan tick (DIV ≥ 2).
- DEBOUNCE, default 4: consecutive ticks required to accept a press or a release (≥ 1).
- REPEAT, default 0: ticks between auto-repeat events while held; 0 disables repeat.
- CW, default $clog2(ROWS*COLS): key code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_row  in  ROWS  raw row lines, active-high, asynchronous to clk.
- key_col  out  COLS  one-hot column drive, active-high.
- key_code  out  CW  code of the current/last key: row*COLS + col.
- key_valid  out  1  one-clk pulse: press accepted, or repeat.
- key_rpt  out  1  high together with key_valid when the event is a repeat.
- key_release  out  1  one-clk pulse: release accepted.
- key_held  out  1  level: a debounced key is currently held.

## Operation
- Two-flop synchroniser on key_row gives `rs`. All decisions use `rs`.
- Tick counter runs 0..DIV-1. `tick` is high for the one clk where the count is DIV-1, then wraps to 0. The counter free-runs in every state.
- Priority when several rows are high: the lowest row index wins. Other keys are ignored until release.
- State IDLE (reset state): key_col = 0. First tick → SCAN with col = 0.
- State SCAN: key_col = one-hot(col). On tick:
  - If rs != 0: latch row = lowest set bit, keep col, cnt = 1. If DEBOUNCE == 1, act as CONFIRM completion on this same tick; else → CONFIRM.
  - Else: col = (col == COLS-1) ? 0 : col+1.
- State CONFIRM: column frozen. On tick:
  - If rs[row] is high, cnt++. When cnt reaches DEBOUNCE: key_code = row*COLS+col, key_valid pulse, key_rpt = 0, key_held = 1, cnt = 0, rcnt = 0, → HELD.
  - If rs[row] is low: → SCAN, col advances (wrap rule). No event.
- State HELD: column frozen. On tick:
  - If rs[row] is low: cnt++. When cnt reaches DEBOUNCE: key_release pulse, key_held = 0, → SCAN, col advances.
  - If rs[row] is high: cnt = 0. If REPEAT ≠ 0: rcnt++. When rcnt reaches REPEAT: key_valid = key_rpt = 1 for one clk, rcnt = 0.
- key_code holds its value until the next accepted press. It does not change on release.
- Any DEBOUNCE-length run of ticks is required to be consecutive. A single bounce resets cnt.

## Timing
- Reset (rst low, asynchronous): state = IDLE, key_col = 0, key_code = 0, key_valid = key_rpt = key_release = key_held = 0, all counters 0. Release of reset is not synchronised internally.
- Every output is registered. Pulses are exactly one clk wide and coincide with the tick cycle + 1.
- Each column is driven for a full DIV cycles before it is sampled.
- Press latency, from a stable key_row assertion to key_valid: at most (COLS + DEBOUNCE) × DIV + 3 clk.
- Release latency, from key_row deassertion to key_release: at most DEBOUNCE × DIV + 3 clk.
- key_valid and key_release never occur in the same cycle.
- Reset asserted in any state aborts immediately. No pulse is emitted and no pulse is pending after reset release.

## Test plan
Common setup for the bench: DIV=4, DEBOUNCE=3, ROWS=4, COLS=3, REPEAT=0 unless stated otherwise.

1. Reset values: hold rst low 10 clk → all outputs 0, key_col = 000. Release rst → key_col = 001, then 010, then 100, then 001, advancing on each tick.
2. Clean press: hold key_row = 0010 while col 2 is driven → key_valid pulse once with key_code = 5, key_held = 1. Drop key_row → key_release after 3 ticks, key_held = 0, scan resumes with key_col = 001.
3. Bounce reject: assert key_row[0] on col 0 for 2 ticks, then 0 → no key_valid, scan advances to col 1. A bounce of 1 tick during HELD → no key_release.
4. Multi-key: key_row = 1010 on col 1 → key_code = 4 (row 1). key_row[3] is ignored until release.
5. Auto-repeat: REPEAT=5, hold key 8 (row 2, col 2) → first key_valid with key_rpt = 0, then key_valid with key_rpt = 1 every 5 ticks. Release stops the repeats.
6. Reset mid-HELD: pull rst low while key_held = 1 → outputs cleared in the same cycle. No key_release is ever emitted for that key.
